// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the uart_tx round-robin arbiter
package uart_arb_pkg;
  localparam int BYTE_W = 8;
  localparam int BUSY_TIMEOUT_DEF = 8;
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} arb_state_t;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational rotate-priority picker, first valid index at or above ptr
// Ports: req_valid (N) and ptr in; gnt (one-hot or zero), idx (winner), any_valid out.
module uart_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_valid
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    any_valid = 1'b0;
    j = ptr;
    for (int k = 0; k < N; k++) begin
      if (!any_valid && req_valid[j]) begin
        idx = j;
        any_valid = 1'b1;
      end
      j = (j == IW'(N - 1)) ? '0 : j + 1'b1;
    end
  end
  assign gnt = any_valid ? (N'(1) << idx) : '0;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte producers
// Ports: req_valid/req_data/req_ready producer handshake; tx_start/tx_data/tx_busy to uart_tx;
//        grant_id, active, done (frame complete pulse), err (busy timeout pulse).
// Optional: define UART_ARB_TIMEOUT_EN to abandon a grant when tx_busy never rises.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [IW-1:0]             grant_id,
  output logic                      active,
  output logic                      done,
  output logic                      err
);
  arb_state_t state, state_nxt;
  logic [IW-1:0] ptr, win;
  logic [NUM_REQ-1:0] gnt;
  logic any_valid, tmo, fin;
  logic [BYTE_W-1:0] bytes [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign bytes[g] = req_data[g*BYTE_W +: BYTE_W];
  end
  uart_rr_pick #(.N(NUM_REQ)) u_pick (
    .req_valid(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(win),
    .any_valid(any_valid)
  );
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state == WAIT_BUSY) ? cnt + 1'b1 : '0;
  assign tmo = (state == WAIT_BUSY) && !tx_busy && (cnt == CW'(BUSY_TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif
  // uart_tx keeps busy low for one cycle after start, so only WAIT_DONE treats low busy as completion
  assign fin = (state == WAIT_DONE) && !tx_busy;
  assign req_ready = (state == IDLE) ? gnt : '0;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = any_valid ? START : IDLE;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: state_nxt = tx_busy ? WAIT_DONE : (tmo ? IDLE : WAIT_BUSY);
      WAIT_DONE: state_nxt = fin ? IDLE : WAIT_DONE;
      default:   state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ptr      <= '0;
    end else begin
      tx_start <= state_nxt == START;
      active   <= state_nxt != IDLE;
      done     <= fin;
      err      <= tmo;
      if (state == IDLE && any_valid) begin
        tx_data  <= bytes[win];
        grant_id <= win;
      end
      if (fin || tmo) ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
endmodule
